ysyx_25060170_lsu_ctrl: RTL and testbench

- Load/store stage between EXU and WBU in the single-issue NPC core.
- Takes the EXU address/result plus decoded memory-op controls.
- Runs a request/response transaction with data memory: byte-lane mask and store-data replication on the way out, lane extraction and sign/zero extension on the way in.
- Hands the load data and pass-through sideband to WBU over a valid/ready handshake.

---
 rtl/ysyx_25060170_lsu_ctrl_if.sv | 24 ++
 rtl/ysyx_25060170_lsu_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ysyx_25060170_lsu_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25060170_lsu_ctrl_if.sv
// Data-memory request/response bus between the LSU and the data memory.
// The LSU drives requests (master); the memory answers (slave).
interface ysyx_25060170_lsu_ctrl_if #(
    parameter int XLEN = 32
);
    logic            dmem_req_valid;
    logic            dmem_req_ready;
    logic [XLEN-1:0] dmem_addr;
    logic            dmem_wen;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_wmask;
    logic            dmem_rsp_valid;
    logic [XLEN-1:0] dmem_rsp_data;

    modport master (
        output dmem_req_valid, dmem_addr, dmem_wen, dmem_wdata, dmem_wmask,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_data
    );

    modport slave (
        input  dmem_req_valid, dmem_addr, dmem_wen, dmem_wdata, dmem_wmask,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_data
    );
endinterface

// File: rtl/ysyx_25060170_lsu_ctrl.sv
// Load/store unit between EXU and WBU: accepts one instruction, runs a single
// request/response transaction on the data-memory bus (byte lanes + store
// replication out, lane extraction + extension in), then hands the result
// and registered sideband to WBU over valid/ready.
module ysyx_25060170_lsu_ctrl #(
    parameter int XLEN          = 32,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] exu_result_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [1:0]      mem_op_i,
    input  logic [1:0]      mem_size_i,
    input  logic            mem_unsigned_i,
    input  logic [4:0]      rd_i,
    input  logic [1:0]      regS_i,
    input  logic            RegW_i,
    input  logic [XLEN-1:0] pc_i,
    ysyx_25060170_lsu_ctrl_if.master dmem,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] mem_data_o,
    output logic [XLEN-1:0] exu_result_o,
    output logic [4:0]      rd_o,
    output logic [1:0]      regS_o,
    output logic            RegW_o,
    output logic [XLEN-1:0] pc_o,
    output logic            misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, OUT} state_t;

    state_t state, state_nxt;

    logic            load_q;
    logic            store_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [XLEN-1:0] sd_q;
    logic            req_valid;

    // Decode of the incoming instruction, used only on the accept cycle
    logic in_load, in_store, in_mis, in_trap, accept;

    assign in_load  = (mem_op_i == 2'd1);
    assign in_store = (mem_op_i == 2'd2);
    assign in_mis   = ((mem_size_i == 2'd1) && exu_result_i[0]) ||
                      (mem_size_i[1] && (exu_result_i[1:0] != 2'b00));
    assign in_trap  = MISALIGN_TRAP && (in_load || in_store) && in_mis;
    assign accept   = in_valid && in_ready;

    // Byte-lane enables; half lanes use addr[1] only so an untrapped
    // misaligned half still lands on an aligned halfword.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        if (size[1])
            return 4'b1111;
        else if (size == 2'd1)
            return 4'b0011 << {a[1], 1'b0};
        else
            return 4'b0001 << a;
    endfunction

    function automatic logic [31:0] store_replicate(input logic [1:0] size, input logic [31:0] sd);
        if (size[1])
            return sd;
        else if (size == 2'd1)
            return {2{sd[15:0]}};
        else
            return {4{sd[7:0]}};
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] a,
                                                input logic [1:0] size, input logic uns);
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        b_s = $signed(raw[{a, 3'b000} +: 8]);
        h_s = $signed(raw[{a[1], 4'b0000} +: 16]);
        if (size[1])
            return raw;
        else if (size == 2'd1)
            return uns ? {16'b0, h_s} : 32'(h_s);
        else
            return uns ? {24'b0, b_s} : 32'(b_s);
    endfunction

    assign dmem.dmem_req_valid = req_valid;
    assign dmem.dmem_addr      = {exu_result_o[XLEN-1:2], 2'b00};
    assign dmem.dmem_wen       = store_q;
    assign dmem.dmem_wmask     = store_q ? lane_mask(size_q, exu_result_o[1:0]) : 4'b0000;
    assign dmem.dmem_wdata     = store_replicate(size_q, sd_q);

    // State register; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and handshake outputs, all decoded from the current state
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        req_valid = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = (in_trap || !(in_load || in_store)) ? OUT : REQ;
            end
            REQ: begin
                req_valid = 1'b1;
                if (dmem.dmem_req_ready)
                    state_nxt = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (dmem.dmem_rsp_valid)
                    state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the instruction on accept and the load result on response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_q       <= 1'b0;
            store_q      <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            sd_q         <= '0;
            mem_data_o   <= '0;
            exu_result_o <= '0;
            rd_o         <= 5'd0;
            regS_o       <= 2'b00;
            RegW_o       <= 1'b0;
            pc_o         <= '0;
            misalign_o   <= 1'b0;
        end else if (accept) begin
            load_q       <= in_load && !in_trap;
            store_q      <= in_store && !in_trap;
            size_q       <= mem_size_i;
            uns_q        <= mem_unsigned_i;
            sd_q         <= store_data_i;
            mem_data_o   <= '0;
            exu_result_o <= exu_result_i;
            rd_o         <= rd_i;
            regS_o       <= regS_i;
            RegW_o       <= RegW_i && !in_trap;
            pc_o         <= pc_i;
            misalign_o   <= in_trap;
        end else if (state == WAIT_RSP && dmem.dmem_rsp_valid) begin
            mem_data_o   <= load_q ? load_extend(dmem.dmem_rsp_data, exu_result_o[1:0], size_q, uns_q)
                                   : '0;
        end
    end

endmodule

// File: tb/tb_ysyx_25060170_lsu_ctrl.sv
// Directed bench for the load/store unit: a vector table of transactions
// plus hand-written reset-abort sequences.
module tb_ysyx_25060170_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] exu_result_i = '0;
    logic [31:0] store_data_i = '0;
    logic [1:0]  mem_op_i = '0;
    logic [1:0]  mem_size_i = '0;
    logic        mem_unsigned_i = 1'b0;
    logic [4:0]  rd_i = '0;
    logic [1:0]  regS_i = '0;
    logic        RegW_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] mem_data_o;
    logic [31:0] exu_result_o;
    logic [4:0]  rd_o;
    logic [1:0]  regS_o;
    logic        RegW_o;
    logic [31:0] pc_o;
    logic        misalign_o;

    int total = 0;
    int bad   = 0;

    ysyx_25060170_lsu_ctrl_if #(.XLEN(32)) dmem ();

    ysyx_25060170_lsu_ctrl #(.XLEN(32), .MISALIGN_TRAP(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .exu_result_i   (exu_result_i),
        .store_data_i   (store_data_i),
        .mem_op_i       (mem_op_i),
        .mem_size_i     (mem_size_i),
        .mem_unsigned_i (mem_unsigned_i),
        .rd_i           (rd_i),
        .regS_i         (regS_i),
        .RegW_i         (RegW_i),
        .pc_i           (pc_i),
        .dmem           (dmem),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .mem_data_o     (mem_data_o),
        .exu_result_o   (exu_result_o),
        .rd_o           (rd_o),
        .regS_o         (regS_o),
        .RegW_o         (RegW_o),
        .pc_o           (pc_o),
        .misalign_o     (misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        regw;
        logic [31:0] rsp;
        int          dly;
        logic        stall;
        logic        exp_req;
        logic        exp_wen;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_mem;
        logic        exp_mis;
        logic        exp_regw;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive_in(input vec_t v, input int idx);
        in_valid       = 1'b1;
        exu_result_i   = v.addr;
        store_data_i   = v.sd;
        mem_op_i       = v.op;
        mem_size_i     = v.size;
        mem_unsigned_i = v.uns;
        rd_i           = v.rd;
        regS_i         = 2'(idx);
        RegW_i         = v.regw;
        pc_i           = 32'h0000_1000 + 32'(idx * 4);
    endtask

    task automatic scramble_in();
        in_valid       = 1'b0;
        exu_result_i   = 32'hFFFF_FFFF;
        store_data_i   = 32'h5555_5555;
        mem_op_i       = 2'd2;
        mem_size_i     = 2'd0;
        mem_unsigned_i = 1'b1;
        rd_i           = 5'd31;
        regS_i         = 2'd3;
        RegW_i         = 1'b1;
        pc_i           = 32'hDEAD_0000;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        chk1($sformatf("v%0d in_ready", idx), in_ready, 1'b1);
        drive_in(v, idx);
        @(negedge clk);
        scramble_in();
        if (v.exp_req) begin
            chk1($sformatf("v%0d req_valid", idx), dmem.dmem_req_valid, 1'b1);
            chk1($sformatf("v%0d out_valid_early", idx), out_valid, 1'b0);
            if (v.stall) begin
                @(negedge clk);
                chk1($sformatf("v%0d req_hold", idx), dmem.dmem_req_valid, 1'b1);
            end
            chk($sformatf("v%0d addr", idx), dmem.dmem_addr, {v.addr[31:2], 2'b00});
            chk1($sformatf("v%0d wen", idx), dmem.dmem_wen, v.exp_wen);
            chk($sformatf("v%0d wmask", idx), {28'b0, dmem.dmem_wmask}, {28'b0, v.exp_wmask});
            chk($sformatf("v%0d wdata", idx), dmem.dmem_wdata, v.exp_wdata);
            dmem.dmem_req_ready = 1'b1;
            @(negedge clk);
            dmem.dmem_req_ready = 1'b0;
            chk1($sformatf("v%0d req_drop", idx), dmem.dmem_req_valid, 1'b0);
            for (int k = 0; k < v.dly; k++) begin
                chk1($sformatf("v%0d wait_out_valid", idx), out_valid, 1'b0);
                @(negedge clk);
            end
            dmem.dmem_rsp_valid = 1'b1;
            dmem.dmem_rsp_data  = v.rsp;
            @(negedge clk);
            dmem.dmem_rsp_valid = 1'b0;
            dmem.dmem_rsp_data  = 32'h5A5A_5A5A;
        end else begin
            chk1($sformatf("v%0d no_req", idx), dmem.dmem_req_valid, 1'b0);
        end
        chk1($sformatf("v%0d out_valid", idx), out_valid, 1'b1);
        chk($sformatf("v%0d mem_data", idx), mem_data_o, v.exp_mem);
        chk1($sformatf("v%0d misalign", idx), misalign_o, v.exp_mis);
        chk1($sformatf("v%0d RegW", idx), RegW_o, v.exp_regw);
        chk($sformatf("v%0d exu_result", idx), exu_result_o, v.addr);
        chk($sformatf("v%0d rd", idx), {27'b0, rd_o}, {27'b0, v.rd});
        chk($sformatf("v%0d regS", idx), {30'b0, regS_o}, 32'(idx % 4));
        chk($sformatf("v%0d pc", idx), pc_o, 32'h0000_1000 + 32'(idx * 4));
        // WBU back-pressure: result must hold
        @(negedge clk);
        chk1($sformatf("v%0d out_hold", idx), out_valid, 1'b1);
        chk($sformatf("v%0d mem_hold", idx), mem_data_o, v.exp_mem);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk1($sformatf("v%0d out_drop", idx), out_valid, 1'b0);
        chk1($sformatf("v%0d in_ready_back", idx), in_ready, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          op     size   uns   addr           sd             rd     regw  rsp            dly stall req   wen   wmask  wdata          mem            mis   regw
        vecs[0]  = '{2'd1, 2'd2, 1'b0, 32'h8000_0004, 32'h0000_0000, 5'd1,  1'b1, 32'h1234_5678, 2, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b1};
        vecs[1]  = '{2'd1, 2'd0, 1'b0, 32'h8000_0003, 32'h0000_0000, 5'd2,  1'b1, 32'h80FF_0000, 1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'hFFFF_FF80, 1'b0, 1'b1};
        vecs[2]  = '{2'd1, 2'd0, 1'b1, 32'h8000_0003, 32'h0000_0000, 5'd3,  1'b1, 32'h80FF_0000, 0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0080, 1'b0, 1'b1};
        vecs[3]  = '{2'd2, 2'd1, 1'b0, 32'h8000_0002, 32'h1111_ABCD, 5'd0,  1'b0, 32'hDEAD_BEEF, 3, 1'b1, 1'b1, 1'b1, 4'hC, 32'hABCD_ABCD, 32'h0000_0000, 1'b0, 1'b0};
        vecs[4]  = '{2'd1, 2'd2, 1'b0, 32'h8000_0006, 32'h0000_0000, 5'd7,  1'b1, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[5]  = '{2'd0, 2'd0, 1'b0, 32'h0000_0042, 32'h0000_0000, 5'd5,  1'b1, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        vecs[6]  = '{2'd1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_0000, 5'd6,  1'b1, 32'h8001_7FFF, 0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'hFFFF_8001, 1'b0, 1'b1};
        vecs[7]  = '{2'd1, 2'd1, 1'b1, 32'h8000_0002, 32'h0000_0000, 5'd8,  1'b1, 32'h8001_7FFF, 1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_8001, 1'b0, 1'b1};
        vecs[8]  = '{2'd2, 2'd0, 1'b0, 32'h8000_0001, 32'h0000_00A5, 5'd0,  1'b0, 32'h0000_0000, 0, 1'b0, 1'b1, 1'b1, 4'h2, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0, 1'b0};
        vecs[9]  = '{2'd2, 2'd2, 1'b0, 32'h8000_0008, 32'hCAFE_F00D, 5'd0,  1'b0, 32'hFFFF_FFFF, 1, 1'b1, 1'b1, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1'b0};
        vecs[10] = '{2'd3, 2'd2, 1'b0, 32'h0000_0099, 32'h1234_0000, 5'd9,  1'b1, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        vecs[11] = '{2'd2, 2'd1, 1'b0, 32'h8000_0001, 32'h0000_BEEF, 5'd4,  1'b1, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[12] = '{2'd1, 2'd1, 1'b0, 32'h8000_0000, 32'h0000_0000, 5'd10, 1'b1, 32'h8001_7FFF, 2, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_7FFF, 1'b0, 1'b1};

        dmem.dmem_req_ready = 1'b0;
        dmem.dmem_rsp_valid = 1'b0;
        dmem.dmem_rsp_data  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk1("rst out_valid", out_valid, 1'b0);
        chk1("rst req_valid", dmem.dmem_req_valid, 1'b0);
        chk("rst mem_data", mem_data_o, 32'h0);
        chk("rst exu_result", exu_result_o, 32'h0);
        chk1("rst misalign", misalign_o, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk1("post_rst in_ready", in_ready, 1'b1);

        for (int i = 0; i < 13; i++)
            run_vec(vecs[i], i);

        // Reset while a request is pending: request drops at once
        @(negedge clk);
        drive_in(vecs[0], 0);
        @(negedge clk);
        scramble_in();
        chk1("rreq req_valid", dmem.dmem_req_valid, 1'b1);
        rst = 1'b0;
        #1;
        chk1("rreq req_drop", dmem.dmem_req_valid, 1'b0);
        chk("rreq exu_result", exu_result_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Reset while waiting for the response; the late response is ignored
        @(negedge clk);
        drive_in(vecs[1], 1);
        @(negedge clk);
        scramble_in();
        dmem.dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem.dmem_req_ready = 1'b0;
        chk("rwait rd_before", {27'b0, rd_o}, 32'd2);
        rst = 1'b0;
        #1;
        chk1("rwait out_valid", out_valid, 1'b0);
        chk1("rwait req_valid", dmem.dmem_req_valid, 1'b0);
        chk("rwait mem_data", mem_data_o, 32'h0);
        chk("rwait rd", {27'b0, rd_o}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        dmem.dmem_rsp_valid = 1'b1;
        dmem.dmem_rsp_data  = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem.dmem_rsp_valid = 1'b0;
        chk1("stray out_valid", out_valid, 1'b0);
        chk("stray mem_data", mem_data_o, 32'h0);
        chk1("stray req_valid", dmem.dmem_req_valid, 1'b0);
        chk1("stray in_ready", in_ready, 1'b1);

        // Normal operation resumes after the abort
        run_vec(vecs[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
